debug_trace_sched: RTL and testbench
====================================

Name: debug_trace_sched

Overview:
- Schedules the two per-cycle commit debug buses (slot 0 older, slot 1 younger) onto one golden-trace compare port that takes at most one record per cycle.
- Buffers records in a small in-order FIFO; the trace port is a valid/ready handshake.
- Counts records lost when the FIFO cannot absorb a commit burst.
- Sits between the commit-side debug shadow queue and the testbench trace comparator.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- SKIP_NOWRITE, 0: 1 = records with wen==0 are discarded at input and not counted as drops.
- DROP_W, 16: width of drop counter.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of FIFO, overflow, drop_cnt
- in0_valid  in  1  slot 0 commit record valid
- in0_pc  in  32  slot 0 pc
- in0_wen  in  4  slot 0 byte write strobe
- in0_wnum  in  5  slot 0 architectural dest
- in0_wdata  in  32  slot 0 write data
- in1_valid, in1_pc, in1_wen, in1_wnum, in1_wdata  in  1/32/4/5/32  slot 1, same meaning
- trace_valid  out  1  head record valid
- trace_ready  in  1  consumer accepts head
- trace_pc, trace_wen, trace_wnum, trace_wdata  out  32/4/5/32  head record
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  DROP_W  dropped-record count, saturating

Behaviour:
- Reset (resetn=0, async): rd_ptr, wr_ptr, count, overflow and drop_cnt are all 0. Outputs: trace_valid=0, level=0, overflow=0, drop_cnt=0. FIFO storage is not reset.
- Eligibility: slot i is eligible when ini_valid and !(SKIP_NOWRITE && ini_wen==0). n_in = number of eligible slots (0..2).
- Free space: free = DEPTH - count, using registered count only. A same-cycle pop does NOT add space.
- Enqueue order is always slot 0 then slot 1.
  - free>=n_in: all eligible slots written at wr_ptr, wr_ptr+1 (mod DEPTH).
  - free==1, n_in==2: slot 0 written, slot 1 dropped.
  - free==0: all eligible slots dropped.
  - Only slot 1 eligible: it is written at wr_ptr alone; no hole is left.
- Drops: any drop sets overflow (sticky until clr/reset) and adds the dropped count (1 or 2) to drop_cnt. drop_cnt saturates at all-ones.
- Output (first-word fall-through):
  - trace_valid = (count!=0).
  - trace_* = mem[rd_ptr] when trace_valid, else 0.
  - Pop = trace_valid && trace_ready; rd_ptr advances by 1 mod DEPTH.
- Latency: a record enqueued at edge N is visible on trace_* after edge N, i.e. one cycle. No combinational path from in* to trace_*.
- Simultaneous push and pop: count_next = count + pushed - popped. Pointers wrap independently.
- Handshake: while trace_valid=1 and trace_ready=0, trace_* hold stable. A consumer may not withdraw ready-dependent logic.
- clr: on the next edge, pointers, count, overflow and drop_cnt go to 0, and any same-cycle push and pop are ignored. clr has priority over everything except resetn.
- Reset mid-stream: all contents are lost; trace_valid falls immediately (async).
- level = count.

Test Plan:
- Single stream: in0 records pc=0xBFC00000..0xBFC0000C (wen=F), one per cycle, ready=1 -> trace emits the same 4 pcs in order, each 1 cycle after input; level never exceeds 1.
- Dual commit ordering: in0 pc=0x100 and in1 pc=0x104 in one cycle, then in1-only pc=0x108, ready=1 -> trace order 0x100, 0x104, 0x108; level peaks at 2.
- Backpressure and overflow: ready=0, 5 dual-commit cycles at DEPTH=8 -> first 4 cycles fill the FIFO (level=8); cycle 5 drops both records, so overflow=1 and drop_cnt=2. Then ready=1 -> the 8 oldest records drain in order.
- Partial fit: count=7, ready=0, dual commit pc=0x200/0x204 -> 0x200 stored, 0x204 dropped, drop_cnt+1. Repeat with count=7 and ready=1 -> still drops 0x204, because the pop does not free space.
- SKIP_NOWRITE=1: in0 wen=0 pc=0x300, in1 wen=3 pc=0x304 -> only 0x304 emitted; drop_cnt unchanged.
- Clear and reset: with level=5 and overflow=1, assert clr for 1 cycle -> level=0, overflow=0, drop_cnt=0 next cycle. Deassert resetn mid-drain -> trace_valid=0 with no clock edge.

Source files
------------

// File: rtl/debug_trace_sched.sv
// Merges the two commit debug slots into one in-order trace stream through a small
// first-word-fall-through FIFO, counting records lost when a burst does not fit.
module debug_trace_sched #(
  parameter int DEPTH        = 8,
  parameter bit SKIP_NOWRITE = 1'b0,
  parameter int DROP_W       = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clr,
  input  logic                     in0_valid,
  input  logic [31:0]              in0_pc,
  input  logic [3:0]               in0_wen,
  input  logic [4:0]               in0_wnum,
  input  logic [31:0]              in0_wdata,
  input  logic                     in1_valid,
  input  logic [31:0]              in1_pc,
  input  logic [3:0]               in1_wen,
  input  logic [4:0]               in1_wnum,
  input  logic [31:0]              in1_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [3:0]               trace_wen,
  output logic [4:0]               trace_wnum,
  output logic [31:0]              trace_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  rec_t              mem_q [DEPTH];
  rec_t              mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  rec_t          rec0, rec1, first_rec, head;
  logic          elig0, elig1, pop;
  logic [1:0]    n_in, n_wr, n_drop;
  logic [CW-1:0] free;
  logic [AW-1:0] wr_ptr_nxt1;
  logic [DROP_W:0] drop_sum;

  // Admission decision uses the registered count only; a pop this cycle frees nothing.
  always_comb begin
    rec0      = '{pc: in0_pc, wen: in0_wen, wnum: in0_wnum, wdata: in0_wdata};
    rec1      = '{pc: in1_pc, wen: in1_wen, wnum: in1_wnum, wdata: in1_wdata};
    elig0     = in0_valid && !(SKIP_NOWRITE && (in0_wen == 4'h0));
    elig1     = in1_valid && !(SKIP_NOWRITE && (in1_wen == 4'h0));
    n_in      = {1'b0, elig0} + {1'b0, elig1};
    free      = CW'(DEPTH) - count_q;
    if (free >= CW'(n_in)) begin
      n_wr = n_in;
    end else if (free != '0) begin
      n_wr = 2'd1;
    end else begin
      n_wr = 2'd0;
    end
    n_drop    = n_in - n_wr;
    first_rec = elig0 ? rec0 : rec1;
    pop       = (count_q != '0) && trace_ready;
    wr_ptr_nxt1 = wr_ptr_q + AW'(1);
  end

  // A lone slot-1 record lands at wr_ptr so the FIFO never holds holes.
  always_comb begin
    mem_d = mem_q;
    if (!clr) begin
      if (n_wr != 2'd0) begin
        mem_d[wr_ptr_q] = first_rec;
      end
      if (n_wr == 2'd2) begin
        mem_d[wr_ptr_nxt1] = rec1;
      end
    end
  end

  always_comb begin
    count_d    = count_q + CW'(n_wr) - CW'(pop);
    rd_ptr_d   = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    wr_ptr_d   = wr_ptr_q + AW'(n_wr);
    overflow_d = overflow_q || (n_drop != 2'd0);
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(n_drop);
    drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    if (clr) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    trace_valid = (count_q != '0);
    trace_pc    = trace_valid ? head.pc    : 32'h0;
    trace_wen   = trace_valid ? head.wen   : 4'h0;
    trace_wnum  = trace_valid ? head.wnum  : 5'h0;
    trace_wdata = trace_valid ? head.wdata : 32'h0;
    level       = count_q;
    overflow    = overflow_q;
    drop_cnt    = drop_cnt_q;
  end

endmodule

// File: tb/tb_debug_trace_sched.sv
// Drives two scheduler instances (deep/plain and shallow/skip-nowrite/narrow counter)
// with the same commit stream and compares both against a queue-based reference.
module tb_debug_trace_sched;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic clk = 1'b0;
  logic resetn, clr, trace_ready;
  logic in0_valid, in1_valid;
  logic [31:0] in0_pc, in1_pc, in0_wdata, in1_wdata;
  logic [3:0]  in0_wen, in1_wen;
  logic [4:0]  in0_wnum, in1_wnum;

  logic        tv_a, tv_b, ovf_a, ovf_b;
  logic [31:0] tpc_a, tpc_b, twd_a, twd_b;
  logic [3:0]  twen_a, twen_b;
  logic [4:0]  twn_a, twn_b;
  logic [3:0]  level_a;
  logic [2:0]  level_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rec_t mq[2][$];
  int   depth_m[2] = '{8, 4};
  bit   skip_m[2]  = '{1'b0, 1'b1};
  int   dmax_m[2]  = '{65535, 3};
  int   dropc_m[2];
  bit   ovf_m[2];

  always #5 clk = ~clk;

  debug_trace_sched #(.DEPTH(8), .SKIP_NOWRITE(1'b0), .DROP_W(16)) dut_a (
    .clk(clk), .resetn(resetn), .clr(clr),
    .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_wen(in0_wen), .in0_wnum(in0_wnum), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_wen(in1_wen), .in1_wnum(in1_wnum), .in1_wdata(in1_wdata),
    .trace_valid(tv_a), .trace_ready(trace_ready), .trace_pc(tpc_a), .trace_wen(twen_a),
    .trace_wnum(twn_a), .trace_wdata(twd_a), .level(level_a), .overflow(ovf_a), .drop_cnt(drop_a)
  );

  debug_trace_sched #(.DEPTH(4), .SKIP_NOWRITE(1'b1), .DROP_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .clr(clr),
    .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_wen(in0_wen), .in0_wnum(in0_wnum), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_wen(in1_wen), .in1_wnum(in1_wnum), .in1_wdata(in1_wdata),
    .trace_valid(tv_b), .trace_ready(trace_ready), .trace_pc(tpc_b), .trace_wen(twen_b),
    .trace_wnum(twn_b), .trace_wdata(twd_b), .level(level_b), .overflow(ovf_b), .drop_cnt(drop_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      dropc_m[k] = 0;
      ovf_m[k] = 1'b0;
    end
  endtask

  // Reference: space is judged before this cycle's pop; slot 0 is offered first.
  task automatic model_step();
    rec_t r0, r1;
    r0 = '{pc: in0_pc, wen: in0_wen, wnum: in0_wnum, wdata: in0_wdata};
    r1 = '{pc: in1_pc, wen: in1_wen, wnum: in1_wnum, wdata: in1_wdata};
    if (!resetn || clr) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int  free;
      bit  do_pop, e0, e1;
      free   = depth_m[k] - mq[k].size();
      do_pop = (mq[k].size() != 0) && trace_ready;
      e0 = in0_valid && !(skip_m[k] && in0_wen == 4'h0);
      e1 = in1_valid && !(skip_m[k] && in1_wen == 4'h0);
      if (e0) begin
        if (free > 0) begin mq[k].push_back(r0); free--; end
        else begin ovf_m[k] = 1'b1; if (dropc_m[k] < dmax_m[k]) dropc_m[k]++; end
      end
      if (e1) begin
        if (free > 0) begin mq[k].push_back(r1); free--; end
        else begin ovf_m[k] = 1'b1; if (dropc_m[k] < dmax_m[k]) dropc_m[k]++; end
      end
      if (do_pop) void'(mq[k].pop_front());
    end
  endtask

  task automatic chk_inst(input int k, input logic tv, input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wn, input logic [31:0] wd, input int unsigned lvl,
                          input logic ovf, input int unsigned drp);
    rec_t h;
    string p;
    p = (k == 0) ? "a" : "b";
    h = (mq[k].size() != 0) ? mq[k][0] : '0;
    chk({p, ".trace_valid"}, 64'(tv), 64'(mq[k].size() != 0));
    chk({p, ".trace_pc"},    64'(pc), 64'(h.pc));
    chk({p, ".trace_wen"},   64'(wen), 64'(h.wen));
    chk({p, ".trace_wnum"},  64'(wn), 64'(h.wnum));
    chk({p, ".trace_wdata"}, 64'(wd), 64'(h.wdata));
    chk({p, ".level"},       64'(lvl), 64'(mq[k].size()));
    chk({p, ".overflow"},    64'(ovf), 64'(ovf_m[k]));
    chk({p, ".drop_cnt"},    64'(drp), 64'(dropc_m[k]));
  endtask

  task automatic check_all();
    chk_inst(0, tv_a, tpc_a, twen_a, twn_a, twd_a, level_a, ovf_a, drop_a);
    chk_inst(1, tv_b, tpc_b, twen_b, twn_b, twd_b, level_b, ovf_b, drop_b);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic drive(input bit v0, input logic [31:0] p0, input logic [3:0] w0,
                       input bit v1, input logic [31:0] p1, input logic [3:0] w1);
    in0_valid = v0; in0_pc = p0; in0_wen = w0; in0_wnum = 5'($urandom); in0_wdata = $urandom;
    in1_valid = v1; in1_pc = p1; in1_wen = w1; in1_wnum = 5'($urandom); in1_wdata = $urandom;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic pulse_clr();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; clr = 1'b0; trace_ready = 1'b0;
    idle();
    model_clear();
    #12;
    check_all();
    resetn = 1'b1;
    tick();

    // single stream, one cycle latency
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hBFC0_0000 + 32'(4 * i), 4'hF, 1'b0, 32'h0, 4'h0);
      tick();
      chk("single.head_pc", 64'(tpc_a), 64'(32'hBFC0_0000 + 32'(4 * i)));
    end
    idle(); tick(); tick();

    // dual commit ordering
    drive(1'b1, 32'h100, 4'hF, 1'b1, 32'h104, 4'hF);
    tick();
    chk("dual.level_peak", 64'(level_a), 64'd2);
    drive(1'b0, 32'h0, 4'h0, 1'b1, 32'h108, 4'hF);
    tick();
    idle(); tick(); tick(); tick();

    // backpressure and overflow
    pulse_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(8 * i), 4'hF, 1'b1, 32'h404 + 32'(8 * i), 4'hF);
      tick();
    end
    chk("bp.level_full", 64'(level_a), 64'd8);
    chk("bp.drop_cnt", 64'(drop_a), 64'd2);
    chk("bp.b_drop_sat", 64'(drop_b), 64'd3);
    idle(); trace_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();

    // partial fit, with and without a concurrent pop
    pulse_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 4'hF, 1'b0, 32'h0, 4'h0);
      tick();
    end
    drive(1'b1, 32'h200, 4'hF, 1'b1, 32'h204, 4'hF);
    tick();
    chk("partial.drop1", 64'(drop_a), 64'd1);
    idle(); trace_ready = 1'b1;
    tick();
    drive(1'b1, 32'h200, 4'hF, 1'b1, 32'h204, 4'hF);
    tick();
    chk("partial.pop_no_space", 64'(drop_a), 64'd2);
    chk("partial.level", 64'(level_a), 64'd7);
    idle();
    for (int i = 0; i < 9; i++) tick();

    // write-less records skipped on instance b
    pulse_clr();
    trace_ready = 1'b1;
    drive(1'b1, 32'h300, 4'h0, 1'b1, 32'h304, 4'h3);
    tick();
    chk("skip.head_pc", 64'(tpc_b), 64'h304);
    chk("skip.level", 64'(level_b), 64'd1);
    idle(); tick(); tick();

    // clear with level 5 and overflow set, push and pop ignored
    pulse_clr();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(8 * i), 4'hF, 1'b1, 32'h604 + 32'(8 * i), 4'hF);
      tick();
    end
    drive(1'b1, 32'h700, 4'hF, 1'b0, 32'h0, 4'h0);
    tick();
    idle(); trace_ready = 1'b1;
    tick(); tick(); tick();
    chk("clr.pre_level", 64'(level_a), 64'd5);
    chk("clr.pre_ovf", 64'(ovf_a), 64'd1);
    drive(1'b1, 32'h800, 4'hF, 1'b1, 32'h804, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.level", 64'(level_a), 64'd0);
    chk("clr.ovf", 64'(ovf_a), 64'd0);
    idle(); tick();

    // reset mid-drain drops trace_valid without a clock edge
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h900 + 32'(8 * i), 4'hF, 1'b1, 32'h904 + 32'(8 * i), 4'hF);
      tick();
    end
    idle(); trace_ready = 1'b1;
    tick(); tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst.async_valid_a", 64'(tv_a), 64'd0);
    chk("rst.async_valid_b", 64'(tv_b), 64'd0);
    chk("rst.async_level", 64'(level_a), 64'd0);
    model_clear();
    tick();
    resetn = 1'b1;
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      in0_valid = ($urandom_range(0, 3) != 0);
      in1_valid = ($urandom_range(0, 2) != 0);
      in0_pc = $urandom; in1_pc = $urandom;
      in0_wen = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      in1_wen = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      in0_wnum = 5'($urandom); in1_wnum = 5'($urandom);
      in0_wdata = $urandom; in1_wdata = $urandom;
      trace_ready = ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 79) == 0);
      tick();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
